// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared timing-mode types, mode presets and FSM states
package video_timing_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } timing_mode_t;

  localparam timing_mode_t MODE_640x480_60 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33
  };

  localparam timing_mode_t MODE_800x600_60 = '{
    h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
    v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } vt_state_e;

endpackage

// File: rtl/video_timing_ctrl_if.sv
// rtl/video_timing_ctrl_if.sv - raster timing output bundle towards the encoder/fetch path
interface video_timing_ctrl_if #(
  parameter int X_W = 12,
  parameter int Y_W = 11
);
  logic           hsync;
  logic           vsync;
  logic           data_enable;
  logic           hblank;
  logic           vblank;
  logic [X_W-1:0] pixel_x;
  logic [Y_W-1:0] pixel_y;
  logic           frame_start;
  logic           line_start;
  logic [15:0]    frame_cnt;
  logic           fetch_req;
  logic [Y_W-1:0] fetch_y;
  logic           running;

  modport master (
    output hsync, vsync, data_enable, hblank, vblank, pixel_x, pixel_y,
           frame_start, line_start, frame_cnt, fetch_req, fetch_y, running
  );

  modport slave (
    input  hsync, vsync, data_enable, hblank, vblank, pixel_x, pixel_y,
           frame_start, line_start, frame_cnt, fetch_req, fetch_y, running
  );
endinterface

// File: rtl/video_axis_counter.sv
// rtl/video_axis_counter.sv - wrap counter 0..MAX with terminal-count flag
module video_axis_counter #(
  parameter int W   = 12,
  parameter int MAX = 799
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         tc
);

  assign tc = (q == W'(MAX));

  // count up on inc, wrapping to zero after the terminal value
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= tc ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - parametrised raster timing generator with frame-aligned start/stop
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int X_W      = 12,
  parameter int Y_W      = 11
) (
  input  logic                clk_pixel,
  input  logic                rst,
  input  logic                en,
  video_timing_ctrl_if.master vid
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;

  localparam logic [X_W-1:0] H_ACT_X = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_B_X  = X_W'(HS_START);
  localparam logic [X_W-1:0] HS_E_X  = X_W'(HS_START + H_SYNC);
  localparam logic [Y_W-1:0] V_ACT_Y = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_B_Y  = Y_W'(VS_START);
  localparam logic [Y_W-1:0] VS_E_Y  = Y_W'(VS_START + V_SYNC);
  localparam logic           H_LVL   = (H_POL != 0);
  localparam logic           V_LVL   = (V_POL != 0);

  if (H_TOTAL >= (1 << X_W)) begin : g_bad_x_w
    $error("H_TOTAL does not fit in X_W bits");
  end
  if (V_TOTAL >= (1 << Y_W)) begin : g_bad_y_w
    $error("V_TOTAL does not fit in Y_W bits");
  end

  vt_state_e      state, state_nxt;
  logic           en_q;
  logic           counting;
  logic           frame_end;
  logic [X_W-1:0] h;
  logic [Y_W-1:0] v;
  logic           h_tc, v_tc;
  logic [15:0]    frame_cnt_q;

  logic           d_hsync, d_vsync, d_de, d_hblank, d_vblank;
  logic           d_frame_start, d_line_start, d_fetch;
  logic [Y_W-1:0] next_v, d_fetch_y;

  assign counting  = (state != IDLE);
  assign frame_end = counting && h_tc && v_tc;

  video_axis_counter #(.W(X_W), .MAX(H_TOTAL - 1)) u_h_cnt (
    .clk (clk_pixel),
    .clr (rst || (state == IDLE)),
    .inc (counting),
    .q   (h),
    .tc  (h_tc)
  );

  video_axis_counter #(.W(Y_W), .MAX(V_TOTAL - 1)) u_v_cnt (
    .clk (clk_pixel),
    .clr (rst || (state == IDLE)),
    .inc (counting && h_tc),
    .q   (v),
    .tc  (v_tc)
  );

  // en is registered once at the input; kept out of reset so a held-high en restarts right after reset
  always_ff @(posedge clk_pixel) begin
    en_q <= en;
  end

  // FSM state register
  always_ff @(posedge clk_pixel) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: stopping only completes on the last pixel of a frame
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (en_q) state_nxt = RUN;
      RUN:      if (!en_q) state_nxt = STOPPING;
      STOPPING: begin
        if (en_q)           state_nxt = RUN;
        else if (frame_end) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM output decode from (h, v, state); everything collapses to idle values outside counting
  always_comb begin
    next_v        = v_tc ? '0 : v + 1'b1;
    d_de          = counting && (h < H_ACT_X) && (v < V_ACT_Y);
    d_hblank      = counting && !(h < H_ACT_X);
    d_vblank      = counting && !(v < V_ACT_Y);
    d_hsync       = (counting && (h >= HS_B_X) && (h < HS_E_X)) ? H_LVL : ~H_LVL;
    d_vsync       = (counting && (v >= VS_B_Y) && (v < VS_E_Y)) ? V_LVL : ~V_LVL;
    d_line_start  = counting && (h == '0);
    d_frame_start = counting && (h == '0) && (v == '0);
    d_fetch       = counting && (h == H_ACT_X) && (next_v < V_ACT_Y);
    d_fetch_y     = d_fetch ? next_v : '0;
  end

  // completed-frame counter, bumped on the h/v double wrap
  always_ff @(posedge clk_pixel) begin
    if (rst)            frame_cnt_q <= '0;
    else if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  // single output register stage so every output describes the same counter value
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      vid.hsync       <= ~H_LVL;
      vid.vsync       <= ~V_LVL;
      vid.data_enable <= 1'b0;
      vid.hblank      <= 1'b0;
      vid.vblank      <= 1'b0;
      vid.pixel_x     <= '0;
      vid.pixel_y     <= '0;
      vid.frame_start <= 1'b0;
      vid.line_start  <= 1'b0;
      vid.frame_cnt   <= '0;
      vid.fetch_req   <= 1'b0;
      vid.fetch_y     <= '0;
      vid.running     <= 1'b0;
    end else begin
      vid.hsync       <= d_hsync;
      vid.vsync       <= d_vsync;
      vid.data_enable <= d_de;
      vid.hblank      <= d_hblank;
      vid.vblank      <= d_vblank;
      vid.pixel_x     <= h;
      vid.pixel_y     <= v;
      vid.frame_start <= d_frame_start;
      vid.line_start  <= d_line_start;
      vid.frame_cnt   <= frame_cnt_q;
      vid.fetch_req   <= d_fetch;
      vid.fetch_y     <= d_fetch_y;
      vid.running     <= counting;
    end
  end

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Parametrised raster timing controller that replaces the fixed 640x480 generator at the head of the video output path. It produces syncs with configurable polarity, data enable, blanking flags, pixel coordinates and frame/line pulses for any mode set by parameters. It adds an enable-driven start/stop that only halts on frame boundaries, a frame counter, and a one-line-ahead fetch request for the framebuffer reader. All outputs are registered and mutually aligned for direct connection to the ADV7511.

## Interface
- H_ACTIVE, 640, active pixels per line; H_FP, 16; H_SYNC, 96; H_BP, 48 (all ≥1)
- V_ACTIVE, 480, active lines; V_FP, 10; V_SYNC, 2; V_BP, 33 (all ≥1)
- H_POL, 1, hsync active level (1 = active high); V_POL, 1, vsync active level
- X_W, 12, width of pixel_x / h counter; Y_W, 11, width of pixel_y / fetch_y / v counter
- clk_pixel  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- en  in  1  level; run timing while high, stop at end of frame when low
- hsync  out  1  horizontal sync at H_POL level during pulse
- vsync  out  1  vertical sync at V_POL level during pulse
- data_enable  out  1  active video
- hblank  out  1  h outside active; vblank  out  1  v outside active
- pixel_x  out  X_W  horizontal position; pixel_y  out  Y_W  vertical position
- frame_start  out  1  one-cycle pulse at (0,0)
- line_start  out  1  one-cycle pulse at x=0 of every line
- frame_cnt  out  16  completed-frame counter, wraps
- fetch_req  out  1  one-cycle pulse requesting the next active line
- fetch_y  out  Y_W  line number for fetch_req, valid only while it is high
- running  out  1  high in RUN and STOPPING

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Sync ranges: [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), same for v.
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1). h wraps at H_TOTAL-1. v advances only on h wrap and wraps at V_TOTAL-1.
- FSM states:
  - IDLE: counters held at 0; on en=1 go to RUN, and counting starts next cycle from (0,0).
  - RUN: count; if en=0 go to STOPPING.
  - STOPPING: keep counting; en=1 returns to RUN with no disturbance; at (H_TOTAL-1, V_TOTAL-1) go to IDLE and counters reload to 0.
- Outputs are decoded from (h, v, state) and registered. In IDLE the decode gives syncs inactive, data_enable/hblank/vblank=0, pulses=0, pixel_x/y=0.
- data_enable = h<H_ACTIVE && v<V_ACTIVE. hblank = !(h<H_ACTIVE); vblank = !(v<V_ACTIVE), both only while counting.
- fetch_req: pulses at h==H_ACTIVE when next line n=(v==V_TOTAL-1 ? 0 : v+1) satisfies n<V_ACTIVE; fetch_y=n. The last line of vertical blank therefore requests line 0.
- frame_cnt increments (mod 2^16) on the h/v double wrap while counting, including the final wrap into IDLE.
- Arithmetic: compare in full X_W/Y_W widths. Elaboration asserts H_TOTAL<2^X_W and V_TOTAL<2^Y_W.

## Timing
- Reset (rst sampled high): state IDLE, h=v=0. Next edge: hsync=!H_POL, vsync=!V_POL, all other outputs 0, frame_cnt=0, running=0.
- Latency: en sampled high in IDLE at edge t → counter (0,0) after edge t+1 → outputs for (0,0) (frame_start=1, line_start=1, data_enable=1, running=1) after edge t+2.
- All outputs describe the same counter value; fixed one-cycle pipeline from the counter.
- Stop: output frame with last (H_TOTAL-1, V_TOTAL-1) is always emitted complete; the next cycle shows idle values.
- en toggling mid-frame never truncates or restarts a frame.
- rst mid-frame overrides everything: idle outputs after the next edge, and frame_cnt is cleared.

## Structure
- Package video_timing_pkg: timing-mode typedef struct (active/fp/sync/bp for h and v), localparam presets MODE_640x480_60 and MODE_800x600_60, FSM state enum {IDLE, RUN, STOPPING}.
- One sub-module is natural: video_axis_counter (parametrised wrap counter with terminal-count output), instantiated for h and v.

## Test plan
- Default mode, en=1 constantly: one frame lasts 800×525=420000 cycles between frame_start pulses; 640 data_enable cycles per active line; 307200 per frame; hsync high for 96 cycles starting at pixel_x=656.
- H_POL=0, V_POL=0: hsync/vsync low only in sync ranges. After reset, both are high and data_enable=0.
- Small mode (H 8/2/2/2, V 4/1/1/1): fetch_req at pixel_x=8 on lines 0..2 with fetch_y=1..3, on line 6 with fetch_y=0, and never on lines 3..5.
- en dropped at (x=100, y=200): frame completes to (13,6) in the small mode, or (799,524) in the default; then running=0, frame_cnt incremented once, outputs idle. Re-assert en: frame_start exactly 2 cycles later.
- en pulsed low then high within one frame: no gap and no restart; frame_start period unchanged.
- rst asserted mid-active-line: next cycle idle outputs with frame_cnt=0. With en high, the first frame_start occurs 2 cycles after rst is released.
